// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// ID-stage hazard controller for the 5-stage pipeline. It handles the cases
// that the EX-stage forwarding network cannot resolve:
//   - load-use hazards: bubbles are inserted for LOAD_STALL_CYC cycles
//   - taken branches resolved in EX: the IF/ID and ID/EX registers are flushed
//   - data memory busy: the whole pipeline is frozen
// It also keeps a saturating count of the cycles in which the PC was held.
//
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   rs_ID, rt_ID           source registers of the instruction in ID
//   uses_rs_ID, uses_rt_ID the ID instruction actually reads rs / rt
//   valid_ID               ID holds a real instruction, not a bubble
//   rd_EX                  destination register of the instruction in EX
//   MemRead_EX, WB_EX      the EX instruction is a load / writes back
//   branch_taken_EX        the branch in EX resolved taken this cycle
//   mem_busy               data memory not ready
//   pc_write, ifid_write   PC and IF/ID load enables
//   ifid_flush             IF/ID loads a bubble
//   idex_bubble            ID/EX loads a bubble (control zeroed)
//   pipe_hold              ID/EX, EX/MM and MM/WB hold their contents
//   stall_cnt              saturating count of cycles with pc_write = 0
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
   parameter int REG_W          = 3,
   parameter int LOAD_STALL_CYC = 1,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] rs_ID,
   input  logic [REG_W-1:0] rt_ID,
   input  logic             uses_rs_ID,
   input  logic             uses_rt_ID,
   input  logic             valid_ID,
   input  logic [REG_W-1:0] rd_EX,
   input  logic             MemRead_EX,
   input  logic             WB_EX,
   input  logic             branch_taken_EX,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_t;

   // rem counts the bubble cycles still owed after the first one
   localparam logic [2:0]       REM_INIT = 3'(LOAD_STALL_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t     state;
   state_t     state_nxt;
   logic [2:0] rem;
   logic [2:0] rem_nxt;
   logic       lu_haz;
   logic       eval_run;
   logic       eval_ls;

   // R0 is hardwired to zero, so a load targeting it never creates a hazard
   assign lu_haz = valid_ID & MemRead_EX & WB_EX & (rd_EX != '0)
                 & ((uses_rs_ID & (rs_ID == rd_EX)) | (uses_rt_ID & (rt_ID == rd_EX)));

   // State and remaining-bubble registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         rem   <= 3'd0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
      end
   end

   // Mealy next-state and output logic. MEM_WAIT re-evaluates as RUN or
   // LOAD_STALL in the same cycle, so a mem_busy drop costs no extra cycle.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      state_nxt   = RUN;
      rem_nxt     = rem;
      eval_run    = 1'b0;
      eval_ls     = 1'b0;

      case (state)
         RUN:        eval_run = 1'b1;
         LOAD_STALL: eval_ls  = 1'b1;
         MEM_WAIT: begin
            if (rem != 3'd0) begin
               eval_ls = 1'b1;
            end else begin
               eval_run = 1'b1;
            end
         end
         default: begin
            state_nxt = RUN;
            rem_nxt   = 3'd0;
         end
      endcase

      if ((eval_run || eval_ls) && mem_busy) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_hold  = 1'b1;
         state_nxt  = MEM_WAIT;
      end else if (eval_ls) begin
         // EX holds a bubble here, so a branch indication is ignored
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         rem_nxt     = rem - 3'd1;
         state_nxt   = (rem <= 3'd1) ? RUN : LOAD_STALL;
      end else if (eval_run) begin
         if (branch_taken_EX) begin
            // The ID instruction is squashed, so a coincident hazard is moot
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (lu_haz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
               state_nxt = LOAD_STALL;
               rem_nxt   = REM_INIT;
            end
         end
      end

      // Hold the pipeline inert while reset is asserted
      if (!rst_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         pipe_hold   = 1'b0;
      end
   end

   // Saturating count of cycles in which the PC was not allowed to advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (!pc_write && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench for hazard_stall_unit. Two instances share all inputs:
//   d1: LOAD_STALL_CYC = 1, CNT_W = 16
//   d3: LOAD_STALL_CYC = 3, CNT_W = 4 (small counter to show saturation)
// Outputs are packed as {pc_write, ifid_write, ifid_flush, idex_bubble,
// pipe_hold} and compared with hand-derived constants.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

   localparam logic [4:0] GO    = 5'b11000;
   localparam logic [4:0] STALL = 5'b00010;
   localparam logic [4:0] FLUSH = 5'b11110;
   localparam logic [4:0] BUSY  = 5'b00001;
   localparam logic [4:0] RSTV  = 5'b00110;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] rs, rt, rd;
   logic       urs, urt, valid, mread, wb, br, busy;

   logic        a_pc, a_ifw, a_fl, a_bub, a_hold;
   logic [15:0] a_cnt;
   logic        b_pc, b_ifw, b_fl, b_bub, b_hold;
   logic [3:0]  b_cnt;
   logic [4:0]  a_out, b_out;

   int n_checks = 0;
   int n_fail   = 0;

   assign a_out = {a_pc, a_ifw, a_fl, a_bub, a_hold};
   assign b_out = {b_pc, b_ifw, b_fl, b_bub, b_hold};

   always #5 clk = ~clk;

   hazard_stall_unit #(.REG_W(3), .LOAD_STALL_CYC(1), .CNT_W(16)) d1 (
      .clk(clk), .rst_n(rst_n), .rs_ID(rs), .rt_ID(rt), .uses_rs_ID(urs), .uses_rt_ID(urt),
      .valid_ID(valid), .rd_EX(rd), .MemRead_EX(mread), .WB_EX(wb),
      .branch_taken_EX(br), .mem_busy(busy),
      .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_fl), .idex_bubble(a_bub),
      .pipe_hold(a_hold), .stall_cnt(a_cnt)
   );

   hazard_stall_unit #(.REG_W(3), .LOAD_STALL_CYC(3), .CNT_W(4)) d3 (
      .clk(clk), .rst_n(rst_n), .rs_ID(rs), .rt_ID(rt), .uses_rs_ID(urs), .uses_rt_ID(urt),
      .valid_ID(valid), .rd_EX(rd), .MemRead_EX(mread), .WB_EX(wb),
      .branch_taken_EX(br), .mem_busy(busy),
      .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_fl), .idex_bubble(b_bub),
      .pipe_hold(b_hold), .stall_cnt(b_cnt)
   );

   // Drive one cycle's worth of inputs and let combinational outputs settle
   task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [2:0] t,
                                input logic us, input logic ut, input logic [2:0] d,
                                input logic m, input logic w, input logic b, input logic bz);
      valid = v; rs = s; rt = t; urs = us; urt = ut;
      rd = d; mread = m; wb = w; br = b; busy = bz;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      n_checks++;
      if (a_out !== RSTV) begin n_fail++; $display("[TB] FAIL reset_out_d1: got %b expected %b", a_out, RSTV); end
      n_checks++;
      if (b_out !== RSTV) begin n_fail++; $display("[TB] FAIL reset_out_d3: got %b expected %b", b_out, RSTV); end
      n_checks++;
      if (a_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d expected 0", a_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (a_out !== GO) begin n_fail++; $display("[TB] FAIL reset_release: got %b expected %b", a_out, GO); end
   endtask

   // ALU producer in EX: forwarding covers it, no stall
   task automatic test_forward();
      do_reset();
      applyStimulus(1'b1, 3'd2, 3'd5, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (a_out !== GO) begin n_fail++; $display("[TB] FAIL fwd_d1: got %b expected %b", a_out, GO); end
      n_checks++;
      if (b_out !== GO) begin n_fail++; $display("[TB] FAIL fwd_d3: got %b expected %b", b_out, GO); end
      tick();
      n_checks++;
      if (a_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL fwd_cnt: got %0d expected 0", a_cnt); end
   endtask

   // Single-bubble load-use on rt
   task automatic test_load_use_1();
      do_reset();
      applyStimulus(1'b1, 3'd1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (a_out !== STALL) begin n_fail++; $display("[TB] FAIL lu1_stall: got %b expected %b", a_out, STALL); end
      tick();
      applyStimulus(1'b1, 3'd1, 3'd3, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (a_out !== GO) begin n_fail++; $display("[TB] FAIL lu1_go: got %b expected %b", a_out, GO); end
      n_checks++;
      if (a_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL lu1_cnt: got %0d expected 1", a_cnt); end
   endtask

   // Three-bubble load-use; a branch flag during LOAD_STALL must be ignored
   task automatic test_load_use_3();
      do_reset();
      applyStimulus(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (b_out !== STALL) begin n_fail++; $display("[TB] FAIL lu3_c1: got %b expected %b", b_out, STALL); end
      tick();
      applyStimulus(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (b_out !== STALL) begin n_fail++; $display("[TB] FAIL lu3_c2_br_ignored: got %b expected %b", b_out, STALL); end
      n_checks++;
      if (a_out !== FLUSH) begin n_fail++; $display("[TB] FAIL lu3_d1_flush: got %b expected %b", a_out, FLUSH); end
      tick();
      applyStimulus(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (b_out !== STALL) begin n_fail++; $display("[TB] FAIL lu3_c3: got %b expected %b", b_out, STALL); end
      tick();
      n_checks++;
      if (b_out !== GO) begin n_fail++; $display("[TB] FAIL lu3_c4: got %b expected %b", b_out, GO); end
      n_checks++;
      if (b_cnt !== 4'd3) begin n_fail++; $display("[TB] FAIL lu3_cnt: got %0d expected 3", b_cnt); end
   endtask

   // Load to r0 is harmless; branch beats a simultaneous load-use
   task automatic test_r0_and_branch();
      do_reset();
      applyStimulus(1'b1, 3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (a_out !== GO) begin n_fail++; $display("[TB] FAIL r0_d1: got %b expected %b", a_out, GO); end
      n_checks++;
      if (b_out !== GO) begin n_fail++; $display("[TB] FAIL r0_d3: got %b expected %b", b_out, GO); end
      tick();
      applyStimulus(1'b1, 3'd5, 3'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (a_out !== FLUSH) begin n_fail++; $display("[TB] FAIL br_lu_d1: got %b expected %b", a_out, FLUSH); end
      n_checks++;
      if (b_out !== FLUSH) begin n_fail++; $display("[TB] FAIL br_lu_d3: got %b expected %b", b_out, FLUSH); end
      tick();
      idle();
      n_checks++;
      if (b_out !== GO) begin n_fail++; $display("[TB] FAIL br_after_d3: got %b expected %b", b_out, GO); end
      n_checks++;
      if (b_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL br_cnt: got %0d expected 0", b_cnt); end
   endtask

   // mem_busy for 4 cycles in LOAD_STALL (rem=2), then the 2 owed bubbles
   task automatic test_mem_wait();
      do_reset();
      applyStimulus(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, (i == 0), 1'b1);
         n_checks++;
         if (b_out !== BUSY) begin n_fail++; $display("[TB] FAIL mw_busy_d3[%0d]: got %b expected %b", i, b_out, BUSY); end
         n_checks++;
         if (a_out !== BUSY) begin n_fail++; $display("[TB] FAIL mw_busy_d1[%0d]: got %b expected %b", i, a_out, BUSY); end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         n_checks++;
         if (b_out !== STALL) begin n_fail++; $display("[TB] FAIL mw_bubble[%0d]: got %b expected %b", i, b_out, STALL); end
         if (i == 0) begin
            n_checks++;
            if (a_out !== GO) begin n_fail++; $display("[TB] FAIL mw_d1_resume: got %b expected %b", a_out, GO); end
         end
         tick();
      end
      n_checks++;
      if (b_out !== GO) begin n_fail++; $display("[TB] FAIL mw_run: got %b expected %b", b_out, GO); end
      n_checks++;
      if (b_cnt !== 4'd7) begin n_fail++; $display("[TB] FAIL mw_cnt: got %0d expected 7", b_cnt); end
   endtask

   // Reset asserted while d3 is in LOAD_STALL
   task automatic test_reset_mid_stall();
      do_reset();
      applyStimulus(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      n_checks++;
      if (b_out !== STALL) begin n_fail++; $display("[TB] FAIL rms_in_stall: got %b expected %b", b_out, STALL); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (b_out !== RSTV) begin n_fail++; $display("[TB] FAIL rms_out: got %b expected %b", b_out, RSTV); end
      n_checks++;
      if (b_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL rms_cnt: got %0d expected 0", b_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (b_out !== GO) begin n_fail++; $display("[TB] FAIL rms_run: got %b expected %b", b_out, GO); end
   endtask

   // Long freeze: counters must stop at their maximum
   task automatic test_saturate();
      do_reset();
      applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) tick();
      n_checks++;
      if (b_cnt !== 4'hF) begin n_fail++; $display("[TB] FAIL sat_d3: got %0d expected 15", b_cnt); end
      for (int i = 20; i < 65534; i++) tick();
      n_checks++;
      if (a_cnt !== 16'hFFFE) begin n_fail++; $display("[TB] FAIL sat_pre_d1: got %h expected fffe", a_cnt); end
      for (int i = 0; i < 6; i++) tick();
      n_checks++;
      if (a_cnt !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL sat_d1: got %h expected ffff", a_cnt); end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_forward();
      test_load_use_1();
      test_load_use_3();
      test_r0_and_branch();
      test_mem_wait();
      test_reset_mid_stall();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
